// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issuing core and the RV64M multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV64M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// Optional MULDIV_EARLY_OUT_EN skips the iteration for zero multiplies and trivially small dividends.
module mul_div_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        fn_q, fn_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand decode at accept time: signedness, sign flags and magnitudes.
    logic            in_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] in_a_mag, in_b_mag;

    assign in_div   = bus.funct3[2];
    assign sgn_a    = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign sgn_b    = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
    assign neg_a    = sgn_a & bus.op_a[XLEN-1];
    assign neg_b    = sgn_b & bus.op_b[XLEN-1];
    assign in_a_mag = neg_a ? -bus.op_a : bus.op_a;
    assign in_b_mag = neg_b ? -bus.op_b : bus.op_b;

    // One iteration: hi:lo is the partial product (multiplier in lo) or remainder:dividend/quotient.
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shl_rem;
    logic [XLEN-1:0] sub_diff;
    logic            q_bit;
    logic [XLEN-1:0] step_hi, step_lo;

    assign add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
    assign shl_rem  = {hi_q, lo_q[XLEN-1]};
    assign q_bit    = (shl_rem >= {1'b0, b_mag_q});
    assign sub_diff = shl_rem[XLEN-1:0] - b_mag_q;
    assign step_hi  = fn_q[2] ? (q_bit ? sub_diff : shl_rem[XLEN-1:0]) : add_sum[XLEN:1];
    assign step_lo  = fn_q[2] ? {lo_q[XLEN-2:0], q_bit} : {add_sum[0], lo_q[XLEN-1:1]};

    // Sign correction and result select on the values produced by the final step.
    logic [2*XLEN-1:0] prod_u, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;

    always_comb begin
        prod_u = {step_hi, step_lo};
        prod_s = neg_res_q ? -prod_u : prod_u;
        quot_s = neg_res_q ? -step_lo : step_lo;
        rem_s  = neg_rem_q ? -step_hi : step_hi;
        case (fn_q)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot_s;
            default:                final_res = rem_s;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        fn_d      = fn_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    fn_d      = bus.funct3;
                    a_mag_d   = in_a_mag;
                    b_mag_d   = in_b_mag;
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    hi_d      = '0;
                    lo_d      = in_div ? in_a_mag : in_b_mag;
                    cnt_d     = '0;
                    if (in_div && (bus.op_b == '0)) begin
                        result_d = bus.funct3[1] ? bus.op_a : '1;
                        done_d   = 1'b1;
                        state_d  = FIN;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!in_div && ((bus.op_a == '0) || (bus.op_b == '0))) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = FIN;
                    end
                    else if (in_div && (in_a_mag < in_b_mag)) begin
                        result_d = bus.funct3[1] ? bus.op_a : '0;
                        done_d   = 1'b1;
                        state_d  = FIN;
                    end
`endif
                    else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = final_res;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fn_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fn_q      <= fn_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, busy/done timing, ignored starts and abort by reset.
module tb_mul_div_unit;
    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mul_div_unit_if #(.XLEN(XLEN)) bus ();

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one op; poke_at>0 raises start with other operands in that cycle after accept.
    task automatic run_op(input string tag, input logic [2:0] fn, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                          input int poke_at);
        int   lat         = 0;
        int   busy_cycles = 0;
        logic seen        = 1'b0;
        bus.funct3 = fn;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        while (!seen && lat < 200) begin
            tick();
            lat++;
            bus.start  = (lat == poke_at);
            bus.funct3 = 3'b101;
            bus.op_a   = 64'd10;
            bus.op_b   = 64'd3;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busy_cycles++;
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".result"}, bus.result, exp);
        tick();
        bus.start = 1'b0;
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int done_count;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) tick();
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.result", bus.result, 64'd0);
        reset = 1'b0;
        tick();

        run_op("mul_7_m3", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op("mulhu_ones", 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("mulh_ones", 3'b001, '1, '1, 64'h0, 65, 0);
        run_op("mulhsu_m1_2", 3'b010, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("div_m7_2", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("rem_m7_2", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("div_7_m2", 3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("rem_7_m2", 3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 0);
        run_op("divu_100_7", 3'b101, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op("remu_100_7", 3'b111, 64'd100, 64'd7, 64'd2, 65, 0);
        run_op("divu_by0", 3'b101, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("remu_by0", 3'b111, 64'd100, 64'd0, 64'd100, 1, 0);
        run_op("div_by0", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("rem_by0", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0);
        run_op("div_ovf", 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65, 0);
        run_op("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, '1, 64'h0, 65, 0);
        run_op("mul_busy_start", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 5);
        run_op("mul_fin_start", 3'b000, 64'd3, 64'd5, 64'd15, 65, 65);
        run_op("mulhu_before_abort", 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);

        // Abort an in-flight divide with reset 20 cycles after accept.
        bus.funct3 = 3'b100;
        bus.op_a   = 64'hFFFF_FFFF_FFFF_FFF9;
        bus.op_b   = 64'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort.busy_running", 64'(bus.busy), 64'd1);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.result", bus.result, 64'd0);
        done_count = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.done === 1'b1) done_count++;
        end
        check("abort.no_done", 64'(done_count), 64'd0);

        run_op("mul_after_abort", 3'b000, 64'd6, 64'd7, 64'd42, 65, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
